sys_bus_arbiter: RTL
====================

Name: sys_bus_arbiter

Overview:
Round-robin arbiter sharing the single system data bus (memory/peripheral slave port) between NUM_MASTERS requesters: the CPU data port, the SPI loader and any future DMA or UART loader. It grants one owner at a time and muxes that owner's access signals onto the slave port. It returns slave read data and ready to all masters, qualified per master by grant. It sits between the masters and the bus decoder.

Parameters:
NUM_MASTERS, 3, number of requesters (2..8); index 0 = CPU, 1 = SPI loader.
TIMEOUT_CYCLES, 255, max owned cycles before forced release (only used with BUS_ARB_TIMEOUT_EN).

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  reset, asynchronous, active-low
i_req  in  NUM_MASTERS  per-master bus request, level
o_gnt  out  NUM_MASTERS  per-master grant, registered, one-hot or zero
i_m_addr  in  NUM_MASTERS*32  per-master address, master k at bits [32k+31:32k]
i_m_wr_data  in  NUM_MASTERS*32  per-master write data
i_m_size  in  NUM_MASTERS*4  per-master byte enables
i_m_read  in  NUM_MASTERS  per-master read strobe
i_m_write  in  NUM_MASTERS  per-master write strobe
o_m_rd_data  out  32  slave read data broadcast to all masters
o_m_ready  out  NUM_MASTERS  i_s_ready AND o_gnt[k]
o_s_addr  out  32  muxed address to slave
o_s_wr_data  out  32  muxed write data
o_s_size  out  4  muxed byte enables
o_s_read  out  1  muxed read strobe
o_s_write  out  1  muxed write strobe
i_s_rd_data  in  32  slave read data
i_s_ready  in  1  slave completes access this cycle
o_timeout  out  1  one-cycle pulse on forced release (tied 0 without macro)

Behaviour:
- Reset: o_gnt=0, o_timeout=0, state=ARB, last_owner=NUM_MASTERS-1. All o_s_* = 0 because there is no owner.
- The async reset mid-transfer drops o_gnt and all o_s_* immediately. No transfer is replayed.
- ARB state:
  - If any i_req is set, pick the winner: the first set bit scanning from (last_owner+1) mod NUM_MASTERS upward with wrap.
  - Register owner and last_owner=winner, set o_gnt[winner] next edge, go to OWN.
  - If no i_req is set, stay in ARB.
- OWN state:
  - o_s_* = owner's i_m_* (combinational mux); non-owners are ignored.
  - Completion = (o_s_read|o_s_write) & i_s_ready. On completion: clear o_gnt next edge, return to ARB.
  - Abandon = !i_req[owner] & !i_m_read[owner] & !i_m_write[owner]. Same release as completion.
  - Otherwise hold the grant. Wait states are allowed indefinitely without the macro.
- Latency:
  - The req sampled in ARB at edge t gives o_gnt high from t+1.
  - A zero-wait access completes in the first grant cycle.
  - Each transfer takes at least 2 cycles (ARB + OWN), so back-to-back transfers from the same master alternate 1 idle, 1 grant.
- Masters must hold i_req until the cycle in which they see o_gnt and drive the access.
- A master raising i_req while another master owns the bus waits. There is no preemption.
- Simultaneous requests are resolved only by round-robin order. A master that just completed has lowest priority next arbitration.
- o_m_rd_data = i_s_rd_data always. It is valid only where o_m_ready[k]=1.
- o_s_* = 0 in ARB.

Optional Feature:
BUS_ARB_TIMEOUT_EN.
- Defined:
  - An 8..16-bit counter, sized to TIMEOUT_CYCLES, clears on entering OWN and increments each OWN cycle without completion.
  - When it reaches TIMEOUT_CYCLES, force release: o_gnt cleared next edge, o_timeout pulses high for exactly one cycle on that edge, state=ARB.
  - Completion in the same cycle as expiry counts as completion, with no pulse.
- Undefined: no counter, o_timeout tied 0, grant held until completion or abandon.

Test Plan:
- Reset release, no requests -> o_gnt=0, o_s_*=0 for 10 cycles.
- i_req=3'b010, SPI drives write addr 0x0000_1000, data 0xDEADBEEF, size 4'hF, i_s_ready=1 -> o_gnt=3'b010 one cycle after req; o_s_write=1, o_s_addr=0x1000 in that cycle; o_gnt=0 the cycle after.
- i_req=3'b111 held, every access ready immediately -> grant order 0,1,2,0,1,2, one grant every 2 cycles.
- Master 0 owns, i_m_read=1, i_s_ready low 5 cycles then high with rd_data 0x12345678 -> o_gnt[0] held 6 cycles; o_m_ready=3'b001 and o_m_rd_data=0x12345678 on cycle 6; master 2 requesting meanwhile is granted next.
- Owner drops req with no strobe -> grant released next edge, no slave strobe seen.
- With BUS_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, i_s_ready stuck 0 -> o_gnt drops after 4 OWN cycles, o_timeout=1 for exactly one cycle, next requester granted; assert async reset mid-OWN -> o_gnt=0 immediately.

Source files
------------

// File: rtl/sys_bus_arbiter.sv
// Round-robin owner arbitration of the shared system data bus with owner-muxed slave access.
// Define BUS_ARB_TIMEOUT_EN to force release of an owner after TIMEOUT_CYCLES owned cycles.
module sys_bus_arbiter #(
  parameter int NUM_MASTERS    = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [NUM_MASTERS-1:0]    i_req,
  output logic [NUM_MASTERS-1:0]    o_gnt,
  input  logic [NUM_MASTERS*32-1:0] i_m_addr,
  input  logic [NUM_MASTERS*32-1:0] i_m_wr_data,
  input  logic [NUM_MASTERS*4-1:0]  i_m_size,
  input  logic [NUM_MASTERS-1:0]    i_m_read,
  input  logic [NUM_MASTERS-1:0]    i_m_write,
  output logic [31:0]               o_m_rd_data,
  output logic [NUM_MASTERS-1:0]    o_m_ready,
  output logic [31:0]               o_s_addr,
  output logic [31:0]               o_s_wr_data,
  output logic [3:0]                o_s_size,
  output logic                      o_s_read,
  output logic                      o_s_write,
  input  logic [31:0]               i_s_rd_data,
  input  logic                      i_s_ready,
  output logic                      o_timeout
);

  localparam int OW = $clog2(NUM_MASTERS);

  typedef enum logic {ARB, OWN} state_t;

  state_t        state;
  logic [OW-1:0] owner;
  logic [OW-1:0] last_owner;
  logic [OW-1:0] winner;
  logic          is_own;
  logic          own_req;
  logic          own_read;
  logic          own_write;
  logic          done;
  logic          expire;

  logic [31:0] addr_arr [NUM_MASTERS];
  logic [31:0] data_arr [NUM_MASTERS];
  logic [3:0]  size_arr [NUM_MASTERS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_unpack
      assign addr_arr[gi] = i_m_addr[32*gi +: 32];
      assign data_arr[gi] = i_m_wr_data[32*gi +: 32];
      assign size_arr[gi] = i_m_size[4*gi +: 4];
    end
  endgenerate

  // Scan from farthest to nearest after last_owner so the nearest requester
  // overwrites; offset NUM_MASTERS is last_owner itself, the lowest priority.
  always_comb begin
    int idx;
    idx    = 0;
    winner = last_owner;
    for (int i = NUM_MASTERS; i >= 1; i--) begin
      idx = (int'(last_owner) + i) % NUM_MASTERS;
      if (i_req[idx]) winner = OW'(idx);
    end
  end

  assign is_own    = (state == OWN);
  assign own_req   = i_req[owner];
  assign own_read  = i_m_read[owner];
  assign own_write = i_m_write[owner];

  assign o_s_addr    = is_own ? addr_arr[owner] : 32'd0;
  assign o_s_wr_data = is_own ? data_arr[owner] : 32'd0;
  assign o_s_size    = is_own ? size_arr[owner] : 4'd0;
  assign o_s_read    = is_own & own_read;
  assign o_s_write   = is_own & own_write;

  assign o_m_rd_data = i_s_rd_data;
  assign o_m_ready   = o_gnt & {NUM_MASTERS{i_s_ready}};

  // Completion or abandonment both end ownership; either wins over a timeout.
  assign done = is_own & ((((o_s_read | o_s_write) & i_s_ready))
                          | (~own_req & ~own_read & ~own_write));

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_W   = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 16) ? 16 : CNT_RAW);

  logic [CNT_W-1:0] own_cnt;

  // own_cnt counts owned cycles already elapsed, so this cycle is the last one allowed.
  assign expire = is_own & ~done & (own_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      own_cnt   <= '0;
      o_timeout <= 1'b0;
    end else begin
      o_timeout <= expire;
      if (!is_own) own_cnt <= '0;
      else if (!done) own_cnt <= own_cnt + 1'b1;
    end
  end
`else
  assign expire    = 1'b0;
  assign o_timeout = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= ARB;
      owner      <= '0;
      last_owner <= OW'(NUM_MASTERS - 1);
      o_gnt      <= '0;
    end else begin
      case (state)
        ARB: begin
          if (|i_req) begin
            owner      <= winner;
            last_owner <= winner;
            o_gnt      <= NUM_MASTERS'(1) << winner;
            state      <= OWN;
          end
        end
        OWN: begin
          if (done || expire) begin
            o_gnt <= '0;
            state <= ARB;
          end
        end
        default: begin
          o_gnt <= '0;
          state <= ARB;
        end
      endcase
    end
  end

endmodule
